cpu_cu: RTL and testbench

- Control unit for the RISC CPU. Sequences fetch, decode and execute, and drives every strobe and select of the execution unit (IR load, PC control, register write, address and S-operand muxes, ALU op).
- Takes IR and alu_status {n,z,c} back from the execution unit.
- Owns the memory read/write handshake and a latched flag register used by conditional jumps.

---
 rtl/cpu_cu.sv | 204 ++++++++++++++++++++
 tb/tb_cpu_cu.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_cu.sv
// cpu_cu: control unit for the 16-bit RISC CPU.
// Sequences FETCH -> DECODE -> EXECUTE, drives every strobe and select of the
// execution unit, owns the memory read/write handshake and keeps the latched
// {n,z,c} flag register that conditional jumps test.
//
// Handshake: a memory request (mem_rd or mem_wr) is held high, with a stable
// address select, for every cycle the FSM sits in a memory state; the
// transfer completes in the cycle mem_ready is sampled high, and the FSM
// leaves the state at the end of that cycle. mem_ready is ignored in every
// other state.
module cpu_cu #(
    parameter logic [3:0] ALU_PASS_R = 4'hE,
    parameter logic [3:0] ALU_PASS_S = 4'hF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic [2:0]  alu_status,
    input  logic        mem_ready,
    output logic        ir_ld,
    output logic        pc_inc,
    output logic        pc_ld,
    output logic        pc_sel,
    output logic        reg_we,
    output logic        adr_sel,
    output logic        s_sel,
    output logic [2:0]  w_adr,
    output logic [2:0]  r_adr,
    output logic [2:0]  s_adr,
    output logic [3:0]  alu_op,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        halted,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EX_ALU = 3'd3,
        ST_EX_LD  = 3'd4,
        ST_EX_ST  = 3'd5,
        ST_EX_JMP = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_JN  = 4'hC;
    localparam logic [3:0] OP_JC  = 4'hD;
    localparam logic [3:0] OP_JR  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t      state_q, state_d;
    logic [2:0]  flags_q, flags_d;   // {n,z,c} captured from the last ALU instruction
    logic [3:0]  opcode;
    logic        flag_n, flag_z, flag_c;

    // IR[2:0] is not an operand field of any instruction this unit decodes;
    // IR[7:0] as a displacement is consumed by the execution unit's PC adder.
    logic        unused_ir;

    assign opcode    = IR[15:12];
    assign flag_n    = flags_q[2];
    assign flag_z    = flags_q[1];
    assign flag_c    = flags_q[0];
    assign unused_ir = ^IR[2:0];

    // Register-file addresses are fixed instruction fields in every state.
    assign w_adr = IR[11:9];
    assign r_adr = IR[8:6];
    assign s_adr = IR[5:3];
    assign state = state_q;

    // Next-state and flag-update logic.
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (opcode == OP_NOP) begin
                    state_d = ST_FETCH;
                end else if (opcode < OP_LD) begin
                    state_d = ST_EX_ALU;
                end else if (opcode == OP_LD) begin
                    state_d = ST_EX_LD;
                end else if (opcode == OP_ST) begin
                    state_d = ST_EX_ST;
                end else if (opcode == OP_HLT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EX_JMP;
                end
            end
            ST_EX_ALU: begin
                // Only ALU instructions refresh the flags; everything else keeps them.
                flags_d = alu_status;
                state_d = ST_FETCH;
            end
            ST_EX_LD: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_EX_ST: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_EX_JMP: begin
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // State and flag registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RST;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Output decode: everything idles low; each state raises only its own strobes.
    // ir_ld, pc_inc and the LD reg_we follow mem_ready in the same cycle.
    always_comb begin
        ir_ld   = 1'b0;
        pc_inc  = 1'b0;
        pc_ld   = 1'b0;
        pc_sel  = 1'b0;
        reg_we  = 1'b0;
        adr_sel = 1'b0;
        s_sel   = 1'b0;
        alu_op  = 4'h0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        halted  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_rd = 1'b1;
                ir_ld  = mem_ready;
                pc_inc = mem_ready;
            end
            ST_EX_ALU: begin
                reg_we = 1'b1;
                alu_op = opcode;
            end
            ST_EX_LD: begin
                mem_rd  = 1'b1;
                adr_sel = 1'b1;
                s_sel   = 1'b1;
                alu_op  = ALU_PASS_S;
                reg_we  = mem_ready;
            end
            ST_EX_ST: begin
                mem_wr  = 1'b1;
                adr_sel = 1'b1;
                alu_op  = ALU_PASS_S;
            end
            ST_EX_JMP: begin
                case (opcode)
                    OP_JMP: pc_ld = 1'b1;
                    OP_JZ:  pc_ld = flag_z;
                    OP_JN:  pc_ld = flag_n;
                    OP_JC:  pc_ld = flag_c;
                    OP_JR: begin
                        pc_ld  = 1'b1;
                        pc_sel = 1'b1;
                        alu_op = ALU_PASS_R;
                    end
                    default: pc_ld = 1'b0;
                endcase
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_cu.sv
// tb_cpu_cu: self-checking bench for the cpu_cu control unit.
// Each instruction is described by a cycle-level expected trace built from
// the instruction class (fetch waits, decode, execute length, strobes), while
// the driver applies the same instruction to the DUT and records what it saw.
module tb_cpu_cu;

    localparam int W           = 26;
    localparam int HALT_CYCLES = 24;

    // Strobe bit order: {ir_ld, pc_inc, pc_ld, pc_sel, reg_we, adr_sel, s_sel, mem_rd, mem_wr, halted}
    localparam logic [9:0] B_IRLD  = 10'b1000000000;
    localparam logic [9:0] B_PCINC = 10'b0100000000;
    localparam logic [9:0] B_PCLD  = 10'b0010000000;
    localparam logic [9:0] B_PCSEL = 10'b0001000000;
    localparam logic [9:0] B_WE    = 10'b0000100000;
    localparam logic [9:0] B_ADR   = 10'b0000010000;
    localparam logic [9:0] B_SSEL  = 10'b0000001000;
    localparam logic [9:0] B_MRD   = 10'b0000000100;
    localparam logic [9:0] B_MWR   = 10'b0000000010;
    localparam logic [9:0] B_HLT   = 10'b0000000001;

    // Clock and reset
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] IR = 16'h0000;
    logic [2:0]  alu_status = 3'b000;
    logic        mem_ready = 1'b0;

    logic        ir_ld, pc_inc, pc_ld, pc_sel, reg_we, adr_sel, s_sel;
    logic [2:0]  w_adr, r_adr, s_adr, state;
    logic [3:0]  alu_op;
    logic        mem_rd, mem_wr, halted;

    always #5 clock = ~clock;

    cpu_cu dut (
        .clock      (clock),
        .reset      (reset),
        .IR         (IR),
        .alu_status (alu_status),
        .mem_ready  (mem_ready),
        .ir_ld      (ir_ld),
        .pc_inc     (pc_inc),
        .pc_ld      (pc_ld),
        .pc_sel     (pc_sel),
        .reg_we     (reg_we),
        .adr_sel    (adr_sel),
        .s_sel      (s_sel),
        .w_adr      (w_adr),
        .r_adr      (r_adr),
        .s_adr      (s_adr),
        .alu_op     (alu_op),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .halted     (halted),
        .state      (state)
    );

    // Scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [2:0]   m_flags  = 3'b000;

    function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [9:0] strb,
                                        input logic [3:0] op, input logic [15:0] ir);
        return {st, strb, op, ir[11:9], ir[8:6], ir[5:3]};
    endfunction

    function automatic logic [W-1:0] sample();
        return {state, ir_ld, pc_inc, pc_ld, pc_sel, reg_we, adr_sel, s_sel,
                mem_rd, mem_wr, halted, alu_op, w_adr, r_adr, s_adr};
    endfunction

    // Reference model: expected per-cycle trace of one instruction.
    task automatic model_instr(input logic [15:0] ir, input int fw, input int ew,
                               input logic [2:0] live);
        logic [3:0] opc;
        logic       taken;
        opc = ir[15:12];
        for (int i = 0; i < fw; i++) exp_q.push_back(mk(3'd1, B_MRD, 4'h0, ir));
        exp_q.push_back(mk(3'd1, B_MRD | B_IRLD | B_PCINC, 4'h0, ir));
        exp_q.push_back(mk(3'd2, 10'd0, 4'h0, ir));
        if (opc >= 4'h1 && opc <= 4'h7) begin
            exp_q.push_back(mk(3'd3, B_WE, opc, ir));
            m_flags = live;
        end else if (opc == 4'h8) begin
            for (int i = 0; i < ew; i++) exp_q.push_back(mk(3'd4, B_MRD | B_ADR | B_SSEL, 4'hF, ir));
            exp_q.push_back(mk(3'd4, B_MRD | B_ADR | B_SSEL | B_WE, 4'hF, ir));
        end else if (opc == 4'h9) begin
            for (int i = 0; i <= ew; i++) exp_q.push_back(mk(3'd5, B_MWR | B_ADR, 4'hF, ir));
        end else if (opc == 4'hE) begin
            exp_q.push_back(mk(3'd6, B_PCLD | B_PCSEL, 4'hE, ir));
        end else if (opc >= 4'hA && opc <= 4'hD) begin
            case (opc)
                4'hA:    taken = 1'b1;
                4'hB:    taken = m_flags[1];
                4'hC:    taken = m_flags[2];
                default: taken = m_flags[0];
            endcase
            exp_q.push_back(mk(3'd6, taken ? B_PCLD : 10'd0, 4'h0, ir));
        end else if (opc == 4'hF) begin
            for (int i = 0; i < HALT_CYCLES; i++) exp_q.push_back(mk(3'd7, B_HLT, 4'h0, ir));
        end
    endtask

    // Driver: applies one instruction and records outputs mid-cycle.
    task automatic drive_instr(input logic [15:0] ir, input int fw, input int ew,
                               input logic [2:0] live);
        logic [3:0] opc;
        int         n_exec;
        logic       is_mem;
        opc    = ir[15:12];
        is_mem = (opc == 4'h8) || (opc == 4'h9);
        if (opc == 4'h0)      n_exec = 0;
        else if (is_mem)      n_exec = ew + 1;
        else if (opc == 4'hF) n_exec = HALT_CYCLES;
        else                  n_exec = 1;
        for (int c = 0; c <= fw; c++) begin
            @(negedge clock);
            IR = ir;
            alu_status = live;
            mem_ready = (c == fw);
            #1 obs_q.push_back(sample());
        end
        @(negedge clock);
        mem_ready = 1'($urandom_range(0, 1));
        #1 obs_q.push_back(sample());
        for (int c = 0; c < n_exec; c++) begin
            @(negedge clock);
            if (is_mem) mem_ready = (c == ew);
            else        mem_ready = 1'($urandom_range(0, 1));
            #1 obs_q.push_back(sample());
        end
    endtask

    task automatic run_instr(input logic [15:0] ir, input int fw, input int ew,
                             input logic [2:0] live);
        model_instr(ir, fw, ew, live);
        drive_instr(ir, fw, ew, live);
    endtask

    task automatic do_reset();
        mem_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        IR = 16'h0000;
        alu_status = 3'b000;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        m_flags = 3'b000;
    endtask

    task automatic test_reset();
        logic [W-1:0] o;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1 o = sample();
        checks++;
        if (o !== mk(3'd0, 10'd0, 4'h0, IR)) begin
            failures++; $display("FAIL rst_first got=%h exp=%h", o, mk(3'd0, 10'd0, 4'h0, IR));
        end
        @(negedge clock);
        mem_ready = 1'b0;
        #1 o = sample();
        checks++;
        if (o !== mk(3'd1, B_MRD, 4'h0, IR)) begin
            failures++; $display("FAIL fetch_wait got=%h exp=%h", o, mk(3'd1, B_MRD, 4'h0, IR));
        end
        #2 reset = 1'b1;
        #1 o = sample();
        checks++;
        if (o !== mk(3'd0, 10'd0, 4'h0, IR)) begin
            failures++; $display("FAIL async_reset got=%h exp=%h", o, mk(3'd0, 10'd0, 4'h0, IR));
        end
        @(negedge clock);
        #1 o = sample();
        checks++;
        if (o !== mk(3'd0, 10'd0, 4'h0, IR)) begin
            failures++; $display("FAIL reset_held got=%h exp=%h", o, mk(3'd0, 10'd0, 4'h0, IR));
        end
        reset = 1'b0;
        m_flags = 3'b000;
        #1 o = sample();
        checks++;
        if (o !== mk(3'd0, 10'd0, 4'h0, IR)) begin
            failures++; $display("FAIL rst_cycle got=%h exp=%h", o, mk(3'd0, 10'd0, 4'h0, IR));
        end
        @(negedge clock);
        #1 o = sample();
        checks++;
        if (o !== mk(3'd1, B_MRD, 4'h0, IR)) begin
            failures++; $display("FAIL rst_to_fetch got=%h exp=%h", o, mk(3'd1, B_MRD, 4'h0, IR));
        end
    endtask

    task automatic test_alu_and_waits();
        logic [W-1:0] e, o;
        int n = 0;
        run_instr(16'h1298, 0, 0, 3'b001);
        run_instr(16'h2298, 3, 0, 3'b100);
        run_instr(16'h0000, 1, 0, 3'b111);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL alu_waits cyc%0d got=%h exp=%h", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_load();
        logic [W-1:0] e, o;
        int n = 0;
        run_instr(16'h8280, 0, 2, 3'b011);
        run_instr(16'h8E40, 1, 0, 3'b110);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL load cyc%0d got=%h exp=%h", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_cond_jump();
        logic [W-1:0] e, o;
        int n = 0;
        run_instr(16'h2298, 0, 0, 3'b010);
        run_instr(16'hB0FE, 0, 0, 3'b000);
        run_instr(16'h2298, 0, 0, 3'b000);
        run_instr(16'hB0FE, 0, 0, 3'b010);
        run_instr(16'h3000, 0, 0, 3'b101);
        run_instr(16'h8280, 0, 1, 3'b000);
        run_instr(16'hC010, 0, 0, 3'b000);
        run_instr(16'hD010, 0, 0, 3'b000);
        run_instr(16'hA0F0, 0, 0, 3'b000);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL cond_jump cyc%0d got=%h exp=%h", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_st_jr_hlt();
        logic [W-1:0] e, o;
        int n = 0;
        run_instr(16'h9098, 0, 1, 3'b000);
        run_instr(16'hE080, 0, 0, 3'b000);
        run_instr(16'hF000, 0, 0, 3'b000);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL st_jr_hlt cyc%0d got=%h exp=%h", n, o, e);
            end
            n++;
        end
        do_reset();
    endtask

    task automatic test_reset_mid_load();
        logic [W-1:0] o;
        @(negedge clock);
        IR = 16'h8280;
        mem_ready = 1'b1;
        @(negedge clock);
        mem_ready = 1'b0;
        @(negedge clock);
        #1 o = sample();
        checks++;
        if (o !== mk(3'd4, B_MRD | B_ADR | B_SSEL, 4'hF, IR)) begin
            failures++; $display("FAIL ld_wait got=%h exp=%h", o, mk(3'd4, B_MRD | B_ADR | B_SSEL, 4'hF, IR));
        end
        mem_ready = 1'b1;
        reset = 1'b1;
        #1 o = sample();
        checks++;
        if (o !== mk(3'd0, 10'd0, 4'h0, IR)) begin
            failures++; $display("FAIL ld_reset got=%h exp=%h", o, mk(3'd0, 10'd0, 4'h0, IR));
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [W-1:0] e, o;
        logic [15:0]  ir;
        int n = 0;
        for (int k = 0; k < 80; k++) begin
            ir = 16'($urandom_range(0, 16'hFFFF));
            ir[15:12] = 4'($urandom_range(0, 14));
            run_instr(ir, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      3'($urandom_range(0, 7)));
        end
        run_instr(16'hF123, int'($urandom_range(0, 2)), 0, 3'b000);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL random cyc%0d got=%h exp=%h", n, o, e);
            end
            n++;
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_alu_and_waits();
        test_load();
        test_cond_jump();
        test_st_jr_hlt();
        test_reset_mid_load();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
